// File: rtl/ctrl_fifo_stack_if.sv
// Handshake and data bundle between a narrow producer / wide consumer and the
// width-converting FIFO. The master drives requests, the slave (the FIFO)
// drives status flags and the popped packet.
interface ctrl_fifo_stack_if #(
    parameter int dbits  = 2,
    parameter int rd_pkt = 4
);
    logic                    wr;
    logic                    rd;
    logic [dbits-1:0]        din;
    logic                    empty;
    logic                    full;
    logic [dbits*rd_pkt-1:0] dout;

    modport master (
        output wr, rd, din,
        input  empty, full, dout
    );

    modport slave (
        input  wr, rd, din,
        output empty, full, dout
    );
endinterface

// File: rtl/ctrl_fifo_stack.sv
// Width-converting FIFO: one dbits word is written per clock, and a packet of
// rd_pkt words (oldest word in the LSBs) is popped per accepted read. A read is
// only possible once a whole packet is buffered. Flags come straight from the
// occupancy register; dout is registered and holds until the next accepted read.
module ctrl_fifo_stack #(
    parameter int abits  = 4,
    parameter int dbits  = 2,
    parameter int rd_pkt = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    ctrl_fifo_stack_if.slave   bus
);
    localparam int DEPTH = 2 ** abits;
    localparam int CNT_W = abits + 1;

    logic [dbits-1:0]        mem_q [DEPTH];
    logic [abits-1:0]        wr_ptr_q, wr_ptr_d;
    logic [abits-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [dbits*rd_pkt-1:0] dout_q, dout_d;
    logic                    wr_acc;
    logic                    rd_acc;

    // Flags and acceptance use pre-edge occupancy, so wr and rd on the same
    // edge are judged independently of each other.
    assign bus.full  = (count_q == CNT_W'(DEPTH));
    assign bus.empty = (count_q < CNT_W'(rd_pkt));
    assign wr_acc    = bus.wr & ~bus.full;
    assign rd_acc    = bus.rd & ~bus.empty;
    assign bus.dout  = dout_q;

    // Next-state for pointers, occupancy and the outgoing packet.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips the assignment infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        count_d  = count_q + CNT_W'(wr_acc) - (rd_acc ? CNT_W'(rd_pkt) : '0);
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            // The abits-wide index sum wraps modulo DEPTH, so a packet may
            // straddle the end of the array. Memory reads here see pre-edge
            // contents, so a same-edge write never leaks into the packet.
            for (int i = 0; i < rd_pkt; i++) begin
                dout_d[i*dbits +: dbits] = mem_q[rd_ptr_q + abits'(i)];
            end
            // Truncation makes an rd_pkt of DEPTH a full lap (no movement).
            rd_ptr_d = rd_ptr_q + abits'(rd_pkt);
        end
    end

    // Storage array: written on accepted writes only.
    // NOTE: the data array has no reset; occupancy and pointers alone decide
    // what is valid, and leaving it unreset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    // Control state and output packet register, cleared asynchronously.
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end
endmodule

// File: tb/tb_ctrl_fifo_stack.sv
// Self-checking bench for ctrl_fifo_stack (abits=4, dbits=2, rd_pkt=4).
// Reference model: a queue of stored words plus the last popped packet.
module tb_ctrl_fifo_stack;
    localparam int DEPTH  = 16;
    localparam int PKT    = 4;
    localparam int DBITS  = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    ctrl_fifo_stack_if #(.dbits(DBITS), .rd_pkt(PKT)) bus ();

    ctrl_fifo_stack #(.abits(4), .dbits(DBITS), .rd_pkt(PKT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DBITS-1:0]     model_q[$];
    logic [DBITS*PKT-1:0] model_dout = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_empty"}, 32'(bus.empty), 32'(model_q.size() < PKT));
        check({tag, "_full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
        check({tag, "_dout"},  32'(bus.dout),  32'(model_dout));
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge from pre-edge occupancy, compare shortly after.
    task automatic step(input logic w, input logic r, input logic [DBITS-1:0] d, input string tag);
        bit full_m, empty_m;
        @(negedge clk);
        bus.wr  = w;
        bus.rd  = r;
        bus.din = d;
        full_m  = (model_q.size() == DEPTH);
        empty_m = (model_q.size() < PKT);
        @(posedge clk);
        if (r && !empty_m) begin
            for (int i = 0; i < PKT; i++) begin
                model_dout[i*DBITS +: DBITS] = model_q.pop_front();
            end
        end
        if (w && !full_m) begin
            model_q.push_back(d);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
    endtask

    initial begin
        logic [DBITS-1:0] basic_data [4];
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
        bus.din = '0;

        // 1. Reset asserted from time 0, checked before any clock edge.
        #3;
        check_outputs("reset");
        @(negedge clk);
        #2 reset_n = 1'b1;

        // 2. Basic packet 1,2,3,2 -> 8'hB9.
        basic_data = '{2'd1, 2'd2, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, basic_data[i], "basic_wr");
        step(1'b0, 1'b1, 2'd0, "basic_rd");
        check("basic_b9", 32'(bus.dout), 32'h0000_00B9);

        // 3. Fill with 20 writes (last 4 dropped), then drain 4 packets.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'(i * 3 + 1), "fill_wr");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'd0, "fill_rd");

        // 4. Partial packet: read ignored until the 4th word arrives.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'(i), "part_wr");
        step(1'b0, 1'b1, 2'd0, "part_rd_ignored");
        step(1'b1, 1'b0, 2'd3, "part_wr4");
        step(1'b0, 1'b1, 2'd0, "part_rd");

        // 5. Wrap-around across the DEPTH-1 -> 0 boundary.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 2'($urandom), "wrap_wr12");
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b1, 2'd0, "wrap_rd2");
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, 2'($urandom), "wrap_wr8");
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 2'd0, "wrap_rd3");

        // 6. Simultaneous wr & rd at count=4, then at count=16.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'($urandom), "sim_fill4");
        step(1'b1, 1'b1, 2'd2, "sim_at4");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 2'($urandom), "sim_fill16");
        step(1'b1, 1'b1, 2'd1, "sim_at16");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0, "sim_drain");

        // Randomized traffic with varying write/read bias.
        for (int i = 0; i < 600; i++) begin
            int wbias;
            wbias = (i / 100) % 2 == 0 ? 70 : 30;
            step(($urandom_range(99) < wbias), ($urandom_range(99) < 25),
                 2'($urandom), "rand");
        end

        // Reset mid-operation: flags and dout restored without a clock.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'($urandom), "pre_rst_wr");
        step(1'b0, 1'b1, 2'd0, "pre_rst_rd");
        #2 reset_n = 1'b0;
        model_q.delete();
        model_dout = '0;
        #1;
        check_outputs("mid_reset");
        idle();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(1), $urandom_range(1), 2'($urandom), "post_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
